countm_down: RTL and testbench
==============================

// Module: countm_down
// PURPOSE
//   Programmable modulo-M down counter: Q steps M-1, M-2, ..., 0, then wraps to M-1.
//   It is the down-counting partner of the team's modulo-M up counter.
//   Used for timers, clock dividers and timeouts that count down to a terminal count.
//   Emits a one-cycle borrow pulse on every wrap, so stages can cascade.
// PARAMETERS
//   WIDTH  8  counter and modulus width in bits
// PORTS
//   clk       in   1      rising-edge clock; the block uses this single clock only
//   rst_n     in   1      asynchronous, active-low reset
//   en        in   1      count enable; one step per clk edge while high
//   load      in   1      synchronous load strobe; takes priority over en
//   load_val  in   WIDTH  value to load
//   M         in   WIDTH  modulus; 0 means 2^WIDTH (full range)
//   Q         out  WIDTH  current count
//   borrow    out  1      registered one-cycle pulse on each wrap
//   zero      out  1      combinational: Q == 0
//   oor       out  1      registered one-cycle pulse when Q was out of range and got corrected
// BEHAVIOUR
//   Reset: while rst_n=0, Q=0, borrow=0, oor=0, so zero=1. No clock edge is needed.
//   Effective modulus: Meff = (M==0) ? 2^WIDTH : M, computed in WIDTH+1 bits.
//     Meff-1 always fits in WIDTH bits.
//   M is sampled live at each edge. No shadow register.
//   Per rising edge, in priority order:
//     1 load=1: Q <= (load_val >= Meff) ? Meff-1 : load_val.
//       borrow <= 0. oor <= (load_val >= Meff).
//     2 en=1, Q==0: Q <= Meff-1. borrow <= 1. oor <= 0.
//     3 en=1, Q >= Meff: Q <= Meff-1. borrow <= 0. oor <= 1.
//       This case occurs when M shrinks mid-count.
//     4 en=1, other: Q <= Q-1. borrow <= 0. oor <= 0.
//     5 en=0: Q holds. borrow <= 0. oor <= 0.
//   Latency: Q and the pulses update on the edge that samples the cause.
//     borrow is high in the same cycle Q shows Meff-1.
//   Period: with en held high, borrow asserts every Meff cycles.
//   M=1: Q stays 0 and borrow=1 on every enabled cycle.
//   M=0: counts 2^WIDTH-1 down to 0 and wraps. oor never fires.
//   load and en both high: load wins and no step occurs that cycle.
//   Reset mid-count: Q returns to 0 immediately.
//     The first enabled edge after reset wraps to Meff-1 with borrow=1.
//   Arithmetic is unsigned throughout. No signed compares.
// STRUCTURE
//   Package countm_pkg holds:
//     - localparam default WIDTH
//     - function eff_mod(M) returning WIDTH+1 bits
//     This package is shared with the up counter.
//   No sub-module is warranted. The block is one flat register stage with
//   next-state logic plus the combinational zero flag.
// TESTING
//   T1 reset: drop rst_n mid-count with no clk edge -> Q=0, zero=1, borrow=0 at once.
//   T2 M=5, en=1 from reset -> Q = 4,3,2,1,0,4,...; borrow high exactly when Q=4;
//      period 5 cycles.
//   T3 M=0 (WIDTH=8), en=1 -> Q 255..0 then 255; one borrow per 256 cycles; oor stays 0.
//   T4 M=10, load_val=12, load=1 -> Q=9, oor pulse.
//      Then load_val=3 with load=en=1 -> Q=3, no step, no borrow.
//   T5 M=20 counting, Q=15; switch M to 8 -> next enabled edge Q=7 with oor pulse;
//      then counts 6..0 and wraps to 7 with borrow.
//   T6 M=1, en toggled 1,0,1 -> Q stays 0; borrow = 1,0,1. M=2 -> Q alternates 1,0.

Source files
------------

// File: rtl/countm_pkg.sv
// countm_pkg: shared width default and effective-modulus helper for the modulo-M counters
package countm_pkg;
  localparam int COUNTM_WIDTH = 8;
  // A zero modulus selects the full 2^w range, so the result needs one extra bit
  function automatic logic [32:0] eff_mod(input logic [31:0] m, input int w);
    return (m == 32'd0) ? (33'd1 << w) : {1'b0, m};
  endfunction
endpackage

// File: rtl/countm_down.sv
// countm_down: programmable modulo-M down counter with borrow, zero and out-of-range flags
module countm_down
  import countm_pkg::*;
#(
  parameter int WIDTH = COUNTM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] Q,
  output logic             borrow,
  output logic             zero,
  output logic             oor
);
  logic [WIDTH-1:0] r_q, w_top, w_q_nxt;
  logic [WIDTH:0]   w_meff;
  logic             r_borrow, r_oor, w_ld_oor, w_q_oor, w_borrow_nxt, w_oor_nxt;
  assign w_meff   = (WIDTH+1)'(eff_mod(32'(M), WIDTH));
  assign w_top    = WIDTH'(w_meff - 1'b1);
  assign w_ld_oor = {1'b0, load_val} >= w_meff;
  assign w_q_oor  = {1'b0, r_q} >= w_meff;
  // Q==0 can never be out of range, so the wrap and correction cases are disjoint
  always_comb begin
    w_q_nxt      = load ? (w_ld_oor ? w_top : load_val)
                 : !en ? r_q
                 : (r_q == '0 || w_q_oor) ? w_top : r_q - 1'b1;
    w_borrow_nxt = !load && en && r_q == '0;
    w_oor_nxt    = load ? w_ld_oor : en && w_q_oor;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q      <= '0;
      r_borrow <= 1'b0;
      r_oor    <= 1'b0;
    end else begin
      r_q      <= w_q_nxt;
      r_borrow <= w_borrow_nxt;
      r_oor    <= w_oor_nxt;
    end
  end
  assign Q      = r_q;
  assign borrow = r_borrow;
  assign oor    = r_oor;
  assign zero   = r_q == '0;
endmodule

// File: tb/tb_countm_down.sv
// tb_countm_down: directed stimulus with an integer reference model checked every cycle
module tb_countm_down;
  localparam int W = 8;
  logic         clk = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0, M = '0, Q;
  logic         borrow, zero, oor;
  int           passed = 0, total = 0;
  int           mq = 0, mb = 0, mo = 0;
  countm_down #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .M(M), .Q(Q), .borrow(borrow), .zero(zero), .oor(oor)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got %0d expected %0d at %0t", n, got, exp, $time);
  endtask
  // Reference model: plain integer arithmetic on the effective modulus
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq = 0; mb = 0; mo = 0;
    end else begin
      int me;
      me = (M == 0) ? (1 << W) : int'(M);
      mb = 0; mo = 0;
      if (load) begin
        mo = (int'(load_val) >= me) ? 1 : 0;
        mq = mo ? me - 1 : int'(load_val);
      end else if (en) begin
        if (mq == 0) begin mq = me - 1; mb = 1; end
        else if (mq >= me) begin mq = me - 1; mo = 1; end
        else mq = mq - 1;
      end
    end
  end
  always @(negedge clk) begin
    chk("model_q", int'(Q), mq);
    chk("model_borrow", int'(borrow), mb);
    chk("model_oor", int'(oor), mo);
    chk("model_zero", int'(zero), (mq == 0) ? 1 : 0);
  end
  task automatic cyc(input logic e, input logic l, input int lv, input int m);
    en = e; load = l; load_val = W'(lv); M = W'(m);
    @(negedge clk);
  endtask
  initial begin
    int nb, no;
    repeat (2) @(negedge clk);
    chk("reset_q", int'(Q), 0);
    chk("reset_zero", int'(zero), 1);
    rst_n = 1'b1;
    // T2: M=5 from reset
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0, 5);
      chk("t2_q", int'(Q), 4 - (i % 5));
      chk("t2_borrow", int'(borrow), (i % 5 == 0) ? 1 : 0);
    end
    // T3: full range
    nb = 0; no = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1, 0, 0, 0);
      if (i == 0) chk("t3_first_q", int'(Q), 255);
      nb += int'(borrow); no += int'(oor);
    end
    chk("t3_borrows", nb, 1);
    chk("t3_oor", no, 0);
    chk("t3_end_q", int'(Q), 0);
    // T4: out-of-range load, then load beats en
    cyc(0, 1, 12, 10);
    chk("t4_q", int'(Q), 9);
    chk("t4_oor", int'(oor), 1);
    cyc(1, 1, 3, 10);
    chk("t4_load_q", int'(Q), 3);
    chk("t4_load_borrow", int'(borrow), 0);
    chk("t4_load_oor", int'(oor), 0);
    // T5: modulus shrinks mid-count
    cyc(0, 1, 15, 20);
    chk("t5_ld_q", int'(Q), 15);
    cyc(1, 0, 0, 8);
    chk("t5_q", int'(Q), 7);
    chk("t5_oor", int'(oor), 1);
    for (int i = 6; i >= 0; i--) begin
      cyc(1, 0, 0, 8);
      chk("t5_cnt", int'(Q), i);
    end
    cyc(1, 0, 0, 8);
    chk("t5_wrap_q", int'(Q), 7);
    chk("t5_wrap_borrow", int'(borrow), 1);
    // T6: M=1 and M=2
    cyc(0, 1, 0, 1);
    cyc(1, 0, 0, 1); chk("t6_b1", int'(borrow), 1); chk("t6_q1", int'(Q), 0);
    cyc(0, 0, 0, 1); chk("t6_b0", int'(borrow), 0);
    cyc(1, 0, 0, 1); chk("t6_b2", int'(borrow), 1); chk("t6_q2", int'(Q), 0);
    cyc(1, 0, 0, 2); chk("t6_m2_a", int'(Q), 1);
    cyc(1, 0, 0, 2); chk("t6_m2_b", int'(Q), 0);
    cyc(1, 0, 0, 2); chk("t6_m2_c", int'(Q), 1);
    // T1: async reset mid-count, no clock edge
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_q", int'(Q), 0);
    chk("t1_zero", int'(zero), 1);
    chk("t1_borrow", int'(borrow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0, 5);
    chk("t1_wrap_q", int'(Q), 4);
    chk("t1_wrap_borrow", int'(borrow), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
